// File: rtl/mmio_io_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl_pkg
// Brief    : Bus commands, register address map and CTRL bit positions for
//            the memory-mapped I/O controller.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_io_ctrl_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  localparam logic [8:0] ADDR_SW     = 9'h140;
  localparam logic [8:0] ADDR_LED    = 9'h100;
  localparam logic [8:0] ADDR_COUNT  = 9'h101;
  localparam logic [8:0] ADDR_CTRL   = 9'h102;
  localparam logic [8:0] ADDR_PERIOD = 9'h103;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int CTRL_EXP_BIT  = 15;

endpackage
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer
// Brief    : Prescaled interval timer with auto-reload and sticky expiry flag.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_timer
  import mmio_io_ctrl_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ctrl_we,
  input  logic        i_period_we,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_count,
  output logic [15:0] o_ctrl,
  output logic [15:0] o_period,
  output logic        o_exp
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_pcnt;
  logic [15:0]   r_count;
  logic [15:0]   r_period;
  logic          r_en;
  logic          r_auto;
  logic          r_exp;

  logic          w_tick;
  logic          w_expire;

  assign w_tick   = r_en && (r_pcnt == PW'(PRESCALE - 1));
  // 17-bit compare keeps COUNT from wrapping when PERIOD is 16'hFFFF
  assign w_expire = ({1'b0, r_count} + 17'd1) >= {1'b0, r_period};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt   <= '0;
      r_count  <= '0;
      r_period <= 16'hFFFF;
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_exp    <= 1'b0;
    end else begin
      if (i_ctrl_we) begin
        r_en   <= i_wdata[CTRL_EN_BIT];
        r_auto <= i_wdata[CTRL_AUTO_BIT];
        r_pcnt <= '0;
        if (i_wdata[CTRL_EN_BIT]) begin
          r_count <= '0;
        end
      end else begin
        if (!r_en || w_tick) begin
          r_pcnt <= '0;
        end else begin
          r_pcnt <= r_pcnt + PW'(1);
        end
        if (w_tick) begin
          if (w_expire) begin
            r_count <= '0;
            if (!r_auto) begin
              r_en <= 1'b0;
            end
          end else begin
            r_count <= r_count + 16'd1;
          end
        end
      end

      // An expiry landing on the same edge as a clear must not be lost
      if (w_tick && w_expire) begin
        r_exp <= 1'b1;
      end else if (i_ctrl_we && i_wdata[CTRL_EXP_BIT]) begin
        r_exp <= 1'b0;
      end

      if (i_period_we) begin
        r_period <= i_wdata;
      end
    end
  end

  assign o_count  = r_count;
  assign o_ctrl   = {r_exp, 13'b0, r_auto, r_en};
  assign o_period = r_period;
  assign o_exp    = r_exp;

endmodule
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_ctrl
// Brief    : Memory-mapped switch/LED/timer peripheral for the upper bus half.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int SW_W     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      mem_cmd,
  input  logic [8:0]      mem_addr,
  input  logic [15:0]     write_data,
  output logic [15:0]     read_data,
  output logic            read_en,
  input  logic [SW_W-1:0] SW,
  output logic [SW_W-1:0] LEDR,
  output logic            timer_irq
);

  logic [SW_W-1:0] r_sw_s1;
  logic [SW_W-1:0] r_sw_s2;
  logic [SW_W-1:0] r_led;

  logic            w_sel;
  logic            w_we;
  logic [15:0]     w_count;
  logic [15:0]     w_ctrl;
  logic [15:0]     w_period;
  logic            w_exp;
  logic [15:0]     w_rdata;

  assign w_sel   = mem_addr[8];
  assign w_we    = (mem_cmd == MWRITE) && w_sel;
  assign read_en = (mem_cmd == MREAD) && w_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_led   <= '0;
    end else begin
      r_sw_s1 <= SW;
      r_sw_s2 <= r_sw_s1;
      if (w_we && (mem_addr == ADDR_LED)) begin
        r_led <= write_data[SW_W-1:0];
      end
    end
  end

  mmio_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_ctrl_we   (w_we && (mem_addr == ADDR_CTRL)),
    .i_period_we (w_we && (mem_addr == ADDR_PERIOD)),
    .i_wdata     (write_data),
    .o_count     (w_count),
    .o_ctrl      (w_ctrl),
    .o_period    (w_period),
    .o_exp       (w_exp)
  );

  always_comb begin
    w_rdata = 16'h0000;
    if (read_en) begin
      case (mem_addr)
        ADDR_SW:     w_rdata = 16'(r_sw_s2);
        ADDR_LED:    w_rdata = 16'(r_led);
        ADDR_COUNT:  w_rdata = w_count;
        ADDR_CTRL:   w_rdata = w_ctrl;
        ADDR_PERIOD: w_rdata = w_period;
        default:     w_rdata = 16'h0000;
      endcase
    end
  end

  assign read_data = w_rdata;
  assign LEDR      = r_led;
  assign timer_irq = w_exp;

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_io_ctrl
// Brief    : Directed plus randomized bench for mmio_io_ctrl with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_io_ctrl;

  localparam int PRESCALE = 4;
  localparam int SW_W     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_en;
  logic [7:0]  SW;
  logic [7:0]  LEDR;
  logic        timer_irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: register contents as the bus should see them
  logic [7:0] m_led, m_s1, m_s2;
  bit         m_en, m_auto, m_exp;
  int         m_count, m_period, m_ph;

  mmio_io_ctrl #(
    .PRESCALE (PRESCALE),
    .SW_W     (SW_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .read_en    (read_en),
    .SW         (SW),
    .LEDR       (LEDR),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [8:0] a);
    case (a)
      9'h140:  return {8'h00, m_s2};
      9'h100:  return {8'h00, m_led};
      9'h101:  return 16'(m_count);
      9'h102:  return {m_exp, 13'b0, m_auto, m_en};
      9'h103:  return 16'(m_period);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_reset();
    m_led = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00;
    m_en = 0; m_auto = 0; m_exp = 0;
    m_count = 0; m_period = 65535; m_ph = 0;
  endtask

  // One clock edge of the reference behaviour
  task automatic m_step(input logic rst, input logic [1:0] cmd, input logic [8:0] a,
                        input logic [15:0] wd, input logic [7:0] sw);
    bit we, tick, expire, nen, nexp;
    int ncount, nph;
    if (rst) begin
      m_reset();
      return;
    end
    we     = (cmd == 2'b10) && a[8];
    tick   = m_en && (m_ph == PRESCALE - 1);
    expire = tick && (m_count + 1 >= m_period);
    ncount = m_count; nen = m_en; nexp = m_exp;
    m_s2 = m_s1;
    m_s1 = sw;
    if (we && a == 9'h100) m_led = wd[7:0];
    nph = (m_en && !tick) ? m_ph + 1 : 0;
    if (tick) begin
      if (expire) begin
        ncount = 0;
        nexp   = 1;
        if (!m_auto) nen = 0;
      end else begin
        ncount = m_count + 1;
      end
    end
    if (we && a == 9'h102) begin
      nen    = wd[0];
      m_auto = wd[1];
      nph    = 0;
      ncount = wd[0] ? 0 : m_count;
      if (wd[15] && !expire) nexp = 0;
    end
    if (we && a == 9'h103) m_period = int'(wd);
    m_en = nen; m_count = ncount; m_ph = nph; m_exp = nexp;
  endtask

  task automatic cyc(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] wd,
                     input bit dchk = 0, input logic [15:0] dexp = 16'h0, input string tag = "");
    logic exp_en;
    mem_cmd = cmd; mem_addr = a; write_data = wd;
    @(negedge clk);
    exp_en = (cmd == 2'b01) && a[8];
    chk("read_en", read_en, exp_en);
    chk("read_data", read_data, exp_en ? m_read(a) : 16'h0000);
    chk("LEDR", LEDR, m_led);
    chk("timer_irq", timer_irq, m_exp);
    if (dchk) chk(tag, read_data, dexp);
    @(posedge clk);
    m_step(reset, cmd, a, wd, SW);
    #1;
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] exp, input string tag);
    cyc(2'b01, a, 16'h0, 1, exp, tag);
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    cyc(2'b10, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 9'h000, 16'h0);
  endtask

  initial begin
    logic [8:0]  addr_pool [8];
    logic [8:0]  ra;
    logic [1:0]  rc;
    logic [15:0] rw;

    addr_pool = '{9'h140, 9'h100, 9'h101, 9'h102, 9'h103, 9'h1FF, 9'h0FF, 9'h000};
    reset = 1'b1; mem_cmd = 2'b00; mem_addr = 9'h0; write_data = 16'h0; SW = 8'h00;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(9'h103, 16'hFFFF, "period_rst");
    rd(9'h102, 16'h0000, "ctrl_rst");
    chk("ledr_rst", LEDR, 8'h00);
    chk("irq_rst", timer_irq, 1'b0);

    // Switch synchronizer latency and LED register
    SW = 8'hA5;
    rd(9'h140, 16'h0000, "sw_pre");
    rd(9'h140, 16'h0000, "sw_1clk");
    rd(9'h140, 16'h00A5, "sw_2clk");
    wr(9'h100, 16'h1234);
    chk("ledr_34", LEDR, 8'h34);
    rd(9'h100, 16'h0034, "led_rd");

    // One-shot timer
    wr(9'h103, 16'd3);
    wr(9'h102, 16'h0001);
    idle(4); rd(9'h101, 16'd1, "count_1");
    idle(3); rd(9'h101, 16'd2, "count_2");
    idle(3); rd(9'h102, 16'h8000, "oneshot_exp");
    rd(9'h101, 16'd0, "count_after_exp");
    chk("irq_set", timer_irq, 1'b1);
    wr(9'h102, 16'h8000);
    rd(9'h102, 16'h0000, "w1c_clear");
    chk("irq_clr", timer_irq, 1'b0);

    // Auto-reload, then clear with restart
    wr(9'h103, 16'd2);
    wr(9'h102, 16'h0003);
    idle(7); rd(9'h102, 16'h0003, "auto_pre");
    rd(9'h102, 16'h8003, "auto_exp");
    wr(9'h102, 16'h8003);
    idle(7); rd(9'h102, 16'h0003, "auto_restart_pre");
    rd(9'h102, 16'h8003, "auto_reexp");

    // Clear lands on the expiry tick: the expiry survives
    idle(6);
    wr(9'h102, 16'h8003);
    rd(9'h102, 16'h8003, "simul_set_wins");
    idle(3); rd(9'h101, 16'd1, "count_pre_reset");

    // Reset mid-count
    reset = 1'b1;
    cyc(2'b00, 9'h000, 16'h0);
    reset = 1'b0;
    rd(9'h103, 16'hFFFF, "period_after_rst");
    rd(9'h102, 16'h0000, "ctrl_after_rst");
    rd(9'h101, 16'h0000, "count_after_rst");
    chk("ledr_after_rst", LEDR, 8'h00);

    // Decode boundaries
    wr(9'h100, 16'h0055);
    rd(9'h0FF, 16'h0000, "ram_side_read");
    chk("ram_side_en", read_en, 1'b0);
    wr(9'h000, 16'h00AA);
    chk("ram_side_write", LEDR, 8'h55);
    rd(9'h1FF, 16'h0000, "unmapped_read");

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 6) == 0) SW = 8'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      ra = ($urandom_range(0, 4) == 0) ? 9'($urandom) : addr_pool[$urandom_range(0, 7)];
      rc = 2'($urandom_range(0, 3));
      rw = 16'($urandom);
      if (ra == 9'h103) rw = 16'($urandom_range(0, 6));
      if (ra == 9'h102 && rc == 2'b10 && $urandom_range(0, 5) == 0) rc = 2'b01;
      if (ra == 9'h102) rw[0] = ($urandom_range(0, 3) != 0);
      cyc(rc, ra, rw);
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
